// File: rtl/exec_alu_pipe_if.sv
// Issue-side and result-side signal bundle for the execute-stage ALU.
// Handshake: a transfer happens on a rising edge where valid && ready; valid/payload hold until then, ready never depends on valid.
interface exec_alu_pipe_if #(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16,
    parameter int IMM_W   = 5
) ();
    logic               in_valid;
    logic               in_ready;
    logic [11:0]        alusignals;
    logic               isimmediate;
    logic [DATA_W-1:0]  op1;
    logic [DATA_W-1:0]  op2;
    logic [IMM_W-1:0]   immx;
    logic [INSTR_W-1:0] instrin;
    logic               iswb;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  aluresult;
    logic [INSTR_W-1:0] instrout;
    logic [DATA_W-1:0]  op2_out;
    logic               iswb_out;
    logic               isld_out;
    logic               isst_out;
    logic               zero_flag;
    logic               carry_flag;

    modport master (
        output in_valid, alusignals, isimmediate, op1, op2, immx, instrin, iswb, flush, out_ready,
        input  in_ready, out_valid, aluresult, instrout, op2_out, iswb_out, isld_out, isst_out,
               zero_flag, carry_flag
    );

    modport slave (
        input  in_valid, alusignals, isimmediate, op1, op2, immx, instrin, iswb, flush, out_ready,
        output in_ready, out_valid, aluresult, instrout, op2_out, iswb_out, isld_out, isst_out,
               zero_flag, carry_flag
    );
endinterface

// File: rtl/exec_alu_pipe.sv
// Handshaked execute-stage ALU: single-cycle ops complete in one edge, multiply holds the unit
// for MUL_STAGES cycles; supports branch flush and output backpressure.
module exec_alu_pipe #(
    parameter int DATA_W     = 16,
    parameter int INSTR_W    = 16,
    parameter int IMM_W      = 5,
    parameter int MUL_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    exec_alu_pipe_if.slave bus,
    output logic           dbg_state
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_t;

    localparam int               CNT_W     = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MUL_STAGES - 1);
    localparam logic [DATA_W:0]  SHIFT_LIM = (DATA_W + 1)'(DATA_W);
    localparam bit               MUL_MULTI = (MUL_STAGES > 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] a_in, b_in, alu_res;
    logic [DATA_W:0]   add_sum;
    logic              alu_carry;
    logic              is_mul_op, go_mul;
    logic              slot_free, in_ready_c, accept, mul_done;

    logic [DATA_W-1:0]  m_a, m_b, m_op2, mul_prod;
    logic [INSTR_W-1:0] m_instr;
    logic               m_iswb, m_isld, m_isst;

    logic               out_valid_q;
    logic [DATA_W-1:0]  aluresult_q, op2_out_q;
    logic [INSTR_W-1:0] instrout_q;
    logic               iswb_out_q, isld_out_q, isst_out_q, zero_flag_q, carry_flag_q;

    assign a_in = bus.op1;
    assign b_in = bus.isimmediate ? DATA_W'(bus.immx) : bus.op2;

    // Lower bit index wins; add/ld/st share the adder.
    always_comb begin
        add_sum   = {1'b0, a_in} + {1'b0, b_in};
        alu_res   = '0;
        alu_carry = 1'b0;
        if (|bus.alusignals[2:0]) begin
            alu_res   = add_sum[DATA_W-1:0];
            alu_carry = add_sum[DATA_W];
        end else if (bus.alusignals[3]) begin
            alu_res   = a_in - b_in;
            alu_carry = (a_in < b_in);
        end else if (bus.alusignals[4]) begin
            alu_res = a_in * b_in;
        end else if (bus.alusignals[5]) begin
            if (a_in == b_in)     alu_res = DATA_W'(1);
            else if (a_in > b_in) alu_res = DATA_W'(2);
        end else if (bus.alusignals[6]) begin
            alu_res = b_in;
        end else if (bus.alusignals[7]) begin
            alu_res = a_in | b_in;
        end else if (bus.alusignals[8]) begin
            alu_res = a_in & b_in;
        end else if (bus.alusignals[9]) begin
            alu_res = ~a_in;
        end else if (bus.alusignals[10]) begin
            if ({1'b0, b_in} < SHIFT_LIM) alu_res = a_in << b_in;
        end else if (bus.alusignals[11]) begin
            if ({1'b0, b_in} < SHIFT_LIM) alu_res = a_in >> b_in;
        end
    end

    assign is_mul_op = bus.alusignals[4] && !(|bus.alusignals[3:0]);
    assign go_mul    = is_mul_op && MUL_MULTI;
    assign slot_free = !out_valid_q || bus.out_ready;
    assign mul_prod  = m_a * m_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        mul_done   = 1'b0;
        case (state_q)
            ST_RUN: begin
                in_ready_c = !bus.flush && slot_free;
                accept     = bus.in_valid && in_ready_c;
                if (accept && go_mul) begin
                    state_d = ST_MUL;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_MUL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (slot_free) begin
                    mul_done = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        // A taken branch kills any multiply in progress and blocks completion.
        if (bus.flush) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            mul_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_a     <= '0;
            m_b     <= '0;
            m_op2   <= '0;
            m_instr <= '0;
            m_iswb  <= 1'b0;
            m_isld  <= 1'b0;
            m_isst  <= 1'b0;
        end else if (accept && go_mul) begin
            m_a     <= a_in;
            m_b     <= b_in;
            m_op2   <= bus.op2;
            m_instr <= bus.instrin;
            m_iswb  <= bus.iswb;
            m_isld  <= bus.alusignals[1];
            m_isst  <= bus.alusignals[2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            aluresult_q  <= '0;
            instrout_q   <= '0;
            op2_out_q    <= '0;
            iswb_out_q   <= 1'b0;
            isld_out_q   <= 1'b0;
            isst_out_q   <= 1'b0;
            zero_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept && !go_mul) begin
            out_valid_q  <= 1'b1;
            aluresult_q  <= alu_res;
            instrout_q   <= bus.instrin;
            op2_out_q    <= bus.op2;
            iswb_out_q   <= bus.iswb;
            isld_out_q   <= bus.alusignals[1];
            isst_out_q   <= bus.alusignals[2];
            zero_flag_q  <= (alu_res == '0);
            carry_flag_q <= alu_carry;
        end else if (mul_done) begin
            out_valid_q  <= 1'b1;
            aluresult_q  <= mul_prod;
            instrout_q   <= m_instr;
            op2_out_q    <= m_op2;
            iswb_out_q   <= m_iswb;
            isld_out_q   <= m_isld;
            isst_out_q   <= m_isst;
            zero_flag_q  <= (mul_prod == '0);
            carry_flag_q <= 1'b0;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.aluresult  = aluresult_q;
    assign bus.instrout   = instrout_q;
    assign bus.op2_out    = op2_out_q;
    assign bus.iswb_out   = iswb_out_q;
    assign bus.isld_out   = isld_out_q;
    assign bus.isst_out   = isst_out_q;
    assign bus.zero_flag  = zero_flag_q;
    assign bus.carry_flag = carry_flag_q;
    assign dbg_state      = (state_q == ST_MUL);

endmodule

// File: tb/tb_exec_alu_pipe.sv
// Bench for exec_alu_pipe: directed vector table, multi-cycle corner sequences and a
// randomized run scored against a plain-arithmetic reference model.
module tb_exec_alu_pipe;
  localparam int DATA_W = 16;
  localparam int INSTR_W = 16;
  localparam int IMM_W = 5;
  localparam int MUL_STAGES = 3;
  localparam int W = 53;

  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [11:0] OP_LD  = 12'h002;
  localparam logic [11:0] OP_ST  = 12'h004;
  localparam logic [11:0] OP_SUB = 12'h008;
  localparam logic [11:0] OP_MUL = 12'h010;
  localparam logic [11:0] OP_CMP = 12'h020;
  localparam logic [11:0] OP_MOV = 12'h040;
  localparam logic [11:0] OP_OR  = 12'h080;
  localparam logic [11:0] OP_AND = 12'h100;
  localparam logic [11:0] OP_NOT = 12'h200;
  localparam logic [11:0] OP_LSL = 12'h400;
  localparam logic [11:0] OP_LSR = 12'h800;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dbg_state;

  exec_alu_pipe_if #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .IMM_W(IMM_W)) bus ();

  exec_alu_pipe #(
    .DATA_W(DATA_W), .INSTR_W(INSTR_W), .IMM_W(IMM_W), .MUL_STAGES(MUL_STAGES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit mon_en = 1'b0;
  bit hs_seen = 1'b0;
  bit prev_hold = 1'b0;
  logic [W-1:0] prev_snap = '0;

  typedef struct {
    logic [11:0] sig;
    logic        isimm;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  imm;
    logic [15:0] res;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [11:0] sig, input logic isimm, input logic [15:0] a,
                          input logic [15:0] b, input logic [4:0] imm, input logic [15:0] instr,
                          input logic wb);
    bus.in_valid = 1'b1;
    bus.alusignals = sig;
    bus.isimmediate = isimm;
    bus.op1 = a;
    bus.op2 = b;
    bus.immx = imm;
    bus.instrin = instr;
    bus.iswb = wb;
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] snap();
    return {bus.instrout, bus.op2_out, bus.iswb_out, bus.isld_out, bus.isst_out,
            bus.zero_flag, bus.carry_flag, bus.aluresult};
  endfunction

  // Reference: first set bit in priority order picks the operation, computed with plain integers.
  function automatic logic [16:0] ref_alu(input logic [11:0] sig, input logic isimm,
                                          input logic [15:0] a, input logic [15:0] op2,
                                          input logic [4:0] imm);
    longint ua = longint'(a);
    longint ub = isimm ? longint'(imm) : longint'(op2);
    longint r = 0;
    logic c = 1'b0;
    int k = -1;
    for (int i = 11; i >= 0; i--) if (sig[i]) k = i;
    case (k)
      0, 1, 2: begin r = ua + ub; c = (r > 65535); r = r % 65536; end
      3: begin c = (ua < ub); r = (ua - ub + 65536) % 65536; end
      4: r = (ua * ub) % 65536;
      5: r = (ua == ub) ? 1 : ((ua > ub) ? 2 : 0);
      6: r = ub;
      7: r = ua | ub;
      8: r = ua & ub;
      9: r = 65535 - ua;
      10: r = (ub >= 16) ? 0 : ((ua << ub) % 65536);
      11: r = (ub >= 16) ? 0 : (ua >> ub);
      default: r = 0;
    endcase
    return {c, 16'(r)};
  endfunction

  function automatic logic [11:0] rand_sig();
    int r = $urandom_range(0, 15);
    if (r < 12) return 12'(1 << r);
    if (r == 12) return 12'h000;
    return 12'($urandom);
  endfunction

  // scoreboard monitor for the randomized phase
  always @(negedge clk) begin
    if (mon_en) begin
      logic [16:0] m;
      logic [W-1:0] e;
      hs_seen = bus.in_valid && bus.in_ready;
      if (prev_hold) check("hold_stable", 64'({bus.out_valid, snap()}), 64'({1'b1, prev_snap}));
      if (bus.flush || (bus.out_valid && !bus.out_ready)) check("ready_low", 64'(bus.in_ready), 64'(0));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(snap()), 64'(0) - 64'(1));
        end else begin
          e = exp_q.pop_front();
          check("sb_result", 64'(snap()), 64'(e));
        end
      end
      if (bus.flush) exp_q.delete();
      if (hs_seen) begin
        m = ref_alu(bus.alusignals, bus.isimmediate, bus.op1, bus.op2, bus.immx);
        e = {bus.instrin, bus.op2, bus.iswb, bus.alusignals[1], bus.alusignals[2],
             (m[15:0] == 16'h0), m[16], m[15:0]};
        exp_q.push_back(e);
      end
      prev_hold = bus.out_valid && !bus.out_ready && !bus.flush;
      prev_snap = snap();
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int low;
    int seen;
    logic [15:0] instr;
    logic [15:0] rb;

    vecs[0]  = '{OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 5'd0, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{OP_LSL, 1'b1, 16'h0003, 16'hFFFF, 5'd4, 16'h0030, 1'b0, 1'b0};
    vecs[2]  = '{OP_LSR, 1'b0, 16'h8000, 16'd16,   5'd0, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{OP_SUB, 1'b0, 16'h0005, 16'h0007, 5'd0, 16'hFFFE, 1'b0, 1'b1};
    vecs[4]  = '{OP_SUB, 1'b0, 16'h0007, 16'h0005, 5'd0, 16'h0002, 1'b0, 1'b0};
    vecs[5]  = '{OP_CMP, 1'b0, 16'h0007, 16'h0007, 5'd0, 16'h0001, 1'b0, 1'b0};
    vecs[6]  = '{OP_CMP, 1'b0, 16'h0009, 16'h0007, 5'd0, 16'h0002, 1'b0, 1'b0};
    vecs[7]  = '{OP_CMP, 1'b0, 16'h0003, 16'h0007, 5'd0, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{OP_MOV, 1'b0, 16'hAAAA, 16'h1234, 5'd0, 16'h1234, 1'b0, 1'b0};
    vecs[9]  = '{OP_OR,  1'b0, 16'h0F00, 16'h00F0, 5'd0, 16'h0FF0, 1'b0, 1'b0};
    vecs[10] = '{OP_AND, 1'b0, 16'hF0F0, 16'h3C3C, 5'd0, 16'h3030, 1'b0, 1'b0};
    vecs[11] = '{OP_NOT, 1'b0, 16'h00FF, 16'h1111, 5'd0, 16'hFF00, 1'b0, 1'b0};
    vecs[12] = '{OP_LSL, 1'b0, 16'h0001, 16'd15,   5'd0, 16'h8000, 1'b0, 1'b0};
    vecs[13] = '{OP_LSR, 1'b0, 16'h8000, 16'd15,   5'd0, 16'h0001, 1'b0, 1'b0};
    vecs[14] = '{12'h000, 1'b0, 16'h0005, 16'h0006, 5'd0, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{OP_ADD | OP_SUB, 1'b0, 16'h0002, 16'h0003, 5'd0, 16'h0005, 1'b0, 1'b0};
    vecs[16] = '{OP_LD,  1'b0, 16'h0010, 16'h0020, 5'd0, 16'h0030, 1'b0, 1'b0};
    vecs[17] = '{OP_ST,  1'b0, 16'hFFFF, 16'h0002, 5'd0, 16'h0001, 1'b0, 1'b1};
    vecs[18] = '{OP_CMP | OP_MOV | OP_LSR, 1'b0, 16'h0004, 16'h0004, 5'd0, 16'h0001, 1'b0, 1'b0};
    vecs[19] = '{OP_MOV, 1'b1, 16'h0000, 16'h0000, 5'd31, 16'h001F, 1'b0, 1'b0};
    vecs[20] = '{OP_LSL, 1'b0, 16'h0001, 16'h0100, 5'd0, 16'h0000, 1'b1, 1'b0};

    bus.in_valid = 1'b0;
    bus.alusignals = '0;
    bus.isimmediate = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    bus.immx = '0;
    bus.instrin = '0;
    bus.iswb = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    reset = 1'b1;
    repeat (3) step();
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_fields", 64'(snap()), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;
    step();

    // single-cycle vector table, back to back with out_ready high
    for (int i = 0; i < 21; i++) begin
      instr = 16'h1000 + 16'(i);
      drive_op(vecs[i].sig, vecs[i].isimm, vecs[i].a, vecs[i].b, vecs[i].imm, instr, 1'(i % 2));
      step();
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(1));
      check($sformatf("vec%0d_fields", i), 64'(snap()),
            64'({instr, vecs[i].b, 1'(i % 2), vecs[i].sig[1], vecs[i].sig[2],
                 vecs[i].z, vecs[i].c, vecs[i].res}));
    end
    drive_idle();
    step();
    check("drain_valid", 64'(bus.out_valid), 64'(0));

    // multiply latency and stall
    drive_op(OP_MUL, 1'b0, 16'h0100, 16'h0101, 5'd0, 16'h2222, 1'b1);
    @(negedge clk);
    check("mul_accept_ready", 64'(bus.in_ready), 64'(1));
    step();
    drive_idle();
    lat = 0;
    low = 0;
    while (!bus.out_valid && lat < 20) begin
      if (!bus.in_ready) low++;
      step();
      lat++;
    end
    check("mul_latency", 64'(lat), 64'(MUL_STAGES));
    check("mul_stall_cycles", 64'(low), 64'(MUL_STAGES));
    check("mul_fields", 64'(snap()), 64'({16'h2222, 16'h0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100}));
    check("mul_ready_after", 64'(bus.in_ready), 64'(1));
    step();
    check("mul_consumed", 64'(bus.out_valid), 64'(0));

    // backpressure on a sub result
    bus.out_ready = 1'b0;
    drive_op(OP_SUB, 1'b0, 16'h0005, 16'h0007, 5'd0, 16'h3333, 1'b0);
    step();
    drive_op(OP_ADD, 1'b0, 16'h0001, 16'h0001, 5'd0, 16'h4444, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(bus.in_ready), 64'(0));
      check("bp_held", 64'({bus.out_valid, snap()}),
            64'({1'b1, 16'h3333, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE}));
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(bus.in_ready), 64'(1));
    step();
    check("bp_next_op", 64'({bus.out_valid, bus.instrout, bus.aluresult}), 64'({1'b1, 16'h4444, 16'h0002}));
    drive_idle();
    step();

    // flush during multiply cycle 2 with a held-off op waiting
    drive_op(OP_MUL, 1'b0, 16'h0003, 16'h0004, 5'd0, 16'h5555, 1'b1);
    step();
    drive_op(OP_MOV, 1'b0, 16'h0000, 16'h0055, 5'd0, 16'h6666, 1'b0);
    step();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_ready_low", 64'(bus.in_ready), 64'(0));
    step();
    bus.flush = 1'b0;
    check("flush_state", 64'({bus.out_valid, dbg_state}), 64'(0));
    @(negedge clk);
    check("flush_ready_back", 64'(bus.in_ready), 64'(1));
    step();
    check("flush_next_op", 64'({bus.out_valid, bus.instrout, bus.aluresult}), 64'({1'b1, 16'h6666, 16'h0055}));
    drive_idle();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("flush_killed_mul", 64'(seen), 64'(0));

    // flush drops a held output
    bus.out_ready = 1'b0;
    drive_op(OP_OR, 1'b0, 16'h0001, 16'h0002, 5'd0, 16'h7777, 1'b1);
    step();
    drive_idle();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_held_drop", 64'(bus.out_valid), 64'(0));

    // reset with a held output, then reset mid-multiply
    drive_op(OP_SUB, 1'b0, 16'h0005, 16'h0007, 5'd0, 16'h3131, 1'b1);
    step();
    drive_idle();
    check("pre_reset_held", 64'(bus.out_valid), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_held_fields", 64'({bus.out_valid, snap()}), 64'(0));
    bus.out_ready = 1'b1;
    drive_op(OP_MUL, 1'b0, 16'h0007, 16'h0009, 5'd0, 16'h8888, 1'b1);
    step();
    drive_idle();
    step();
    check("mid_mul_busy", 64'(dbg_state), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_mid_mul", 64'({dbg_state, bus.out_valid, snap()}), 64'(0));
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("reset_killed_mul", 64'(seen), 64'(0));
    drive_op(OP_CMP, 1'b0, 16'h0007, 16'h0007, 5'd0, 16'h9999, 1'b0);
    step();
    drive_idle();
    check("cmp_after_reset", 64'({bus.out_valid, bus.aluresult}), 64'({1'b1, 16'h0001}));
    step();

    // randomized traffic against the reference model
    hs_seen = 1'b0;
    prev_hold = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!bus.in_valid || hs_seen) begin
        if ($urandom_range(0, 9) < 7) begin
          rb = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
          drive_op(rand_sig(), 1'($urandom_range(0, 1)), 16'($urandom), rb, 5'($urandom),
                   16'($urandom), 1'($urandom_range(0, 1)));
        end else begin
          drive_idle();
        end
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush = ($urandom_range(0, 24) == 0);
      step();
    end
    drive_idle();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) step();
    step();
    mon_en = 1'b0;
    check("random_drain", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_alu_pipe.md
Name: exec_alu_pipe

Overview:
Parametrised execute-stage ALU for the superscalar pipeline. It replaces the fixed 16-bit, always-advancing ALU with a valid/ready handshaked unit. Single-cycle ops have 1-cycle latency; the multiplier is multi-cycle and stalls the unit. It also provides branch-flush, output backpressure and result flags. It sits between the operand-fetch/issue stage and the memory stage, and forwards the instruction, store data and writeback control alongside the result.

Parameters:
DATA_W, 16, operand/result width
INSTR_W, 16, instruction word width passed through
IMM_W, 5, immediate width, zero-extended to DATA_W
MUL_STAGES, 2, multiply latency in cycles (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  issue stage presents an op
in_ready  out  1  unit accepts op this cycle
alusignals  in  12  op one-hot: [0]add [1]ld [2]st [3]sub [4]mul [5]cmp [6]mov [7]or [8]and [9]not [10]lsl [11]lsr
isimmediate  in  1  B = zero-extended immx instead of op2
op1  in  DATA_W  operand A
op2  in  DATA_W  operand B / store data
immx  in  IMM_W  immediate
instrin  in  INSTR_W  instruction word
iswb  in  1  writeback-required flag
flush  in  1  branch taken: kill in-flight and held ops
out_valid  out  1  result registers hold a valid op
out_ready  in  1  downstream consumes result this cycle
aluresult  out  DATA_W  result
instrout  out  INSTR_W  instruction of the result
op2_out  out  DATA_W  op2 of the result op (store data)
iswb_out  out  1  writeback flag of the result op
isld_out  out  1  result op is a load
isst_out  out  1  result op is a store
zero_flag  out  1  aluresult == 0
carry_flag  out  1  carry (add/ld/st) or borrow (sub); 0 for other ops

Behaviour:
- Reset: state=RUN; out_valid=0; aluresult, instrout, op2_out=0; iswb_out, isld_out, isst_out, zero_flag, carry_flag=0; mul counter=0.
- Accept rule: accept = in_valid && in_ready.
- in_ready = (state==RUN) && !flush && (!out_valid || out_ready). This is combinational and never depends on in_valid.
- Output slot clears (out_valid<=0) when out_valid && out_ready and nothing new completes in that cycle.
- A held output stays bit-stable while out_valid && !out_ready.
- Single-cycle ops (every op except mul): accepted at edge N, then out_valid=1 with all output fields from edge N onward.
- Mul, RUN->MUL: on accept, capture operands, instr and side fields, and load counter=MUL_STAGES-1.
- While in MUL: in_ready=0 and the counter decrements each cycle. When the counter reaches 0 and the output slot is free or being consumed, write the output and return to RUN.
- Mul latency: out_valid rises MUL_STAGES cycles after accept.
- MUL_STAGES=1 behaves like a single-cycle op.
- If the output slot is blocked when mul finishes, stay in MUL with counter=0 until the slot frees.
- Op priority when several bits are set: add/ld/st > sub > mul > cmp > mov > or > and > not > lsl > lsr.
- If no bit is set, result=0 and the op still flows through, so the instruction is carried to later stages.
- Arithmetic:
  - add/sub/mul are modulo 2^DATA_W; mul keeps the low DATA_W bits.
  - carry_flag = bit DATA_W of A+B for add, or A<B for sub.
  - cmp is unsigned: 1 if A==B, 2 if A>B, 0 otherwise.
  - mov = B; not = ~A.
  - lsl/lsr are logical shifts by B; if B >= DATA_W, result=0.
- isld_out / isst_out = alusignals[1] / [2] of the captured op.
- flush: at the edge where flush=1, out_valid<=0, any MUL is aborted (state<=RUN, counter<=0), and no op is accepted. in_ready is 0 during the flush cycle.
- reset has priority over flush; flush has priority over completion.

Test Plan:
- DATA_W=16: add op1=0xFFFF, op2=0x0001, out_ready=1 -> next cycle aluresult=0x0000, zero_flag=1, carry_flag=1, out_valid=1.
- isimmediate=1 lsl: op1=0x0003, immx=4 -> aluresult=0x0030; then lsr op1=0x8000, op2=16 -> aluresult=0x0000.
- MUL_STAGES=3, mul 0x0100*0x0101 -> in_ready=0 for 3 cycles; out_valid rises 3 cycles after accept; aluresult=0x0100 (low 16 bits of 0x10100).
- Backpressure: out_ready=0 after a sub 5-7 completes -> aluresult=0xFFFE, carry_flag=1, held stable, in_ready=0. Raise out_ready -> the next op is accepted that same cycle.
- flush during MUL cycle 2 with a held-off in_valid op -> next cycle out_valid=0 and state RUN. The new op is accepted only after flush drops, and the killed mul never appears.
- reset mid-mul with out_valid=1 -> all outputs 0 next cycle; a cmp 7 vs 7 issued after reset gives aluresult=0x0001.
